// File: rtl/max31855_spi_rx.sv
// max31855_spi_rx: read-only SPI master (mode 0, MSB first) that clocks one
// NBITS-bit frame out of a MAX31855 and presents it as a parallel word.
// Optional feature: define SPI_CS_GAP_EN to hold cs_n high for at least
// CS_GAP clk cycles between frames (adds a GAP state after HOLD).
module max31855_spi_rx #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned NBITS   = 32,
    parameter int unsigned CS_GAP  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_ena,
    input  logic             miso,
    output logic             cs_n,
    output logic             sclk,
    output logic             spi_not_busy,
    output logic [NBITS-1:0] spi_rx_data,
    output logic             rx_valid
);

    // Elaboration-time parameter range checks
    if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
        $error("CLK_DIV must be in 2..255");
    end
    if (NBITS < 8 || NBITS > 32) begin : g_bad_nbits
        $error("NBITS must be in 8..32");
    end
    if (CS_GAP < 1 || CS_GAP > 65535) begin : g_bad_cs_gap
        $error("CS_GAP must be in 1..65535");
    end

    localparam logic [7:0] DivMax = 8'(CLK_DIV - 1);
    localparam logic [5:0] BitMax = 6'(NBITS);

`ifdef SPI_CS_GAP_EN
    localparam logic [15:0] GapMax = 16'(CS_GAP - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSetup = 3'd1,
        StShift = 3'd2,
        StHold  = 3'd3,
        StGap   = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSetup = 3'd1,
        StShift = 3'd2,
        StHold  = 3'd3
    } state_e;
`endif

    state_e           state;
    state_e           state_next;
    logic [7:0]       div_cnt;
    logic [5:0]       bit_cnt;
    logic [NBITS-1:0] shift_reg;
    logic             tick;
    logic             start;
    logic             rise;
    logic             fall;
    logic             done;
`ifdef SPI_CS_GAP_EN
    logic [15:0]      gap_cnt;
`endif

    // Divider terminal count: one sclk half-period has elapsed
    assign tick = (div_cnt == DivMax);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StIdle;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            StIdle:  if (spi_ena) state_next = StSetup;
            StSetup: if (tick) state_next = StShift;
            // Leave only after the falling edge that follows the last rise
            StShift: if (tick && sclk && (bit_cnt == BitMax)) state_next = StHold;
`ifdef SPI_CS_GAP_EN
            StHold:  if (tick) state_next = StGap;
            StGap:   if (gap_cnt == GapMax) state_next = StIdle;
`else
            StHold:  if (tick) state_next = StIdle;
`endif
            default: state_next = StIdle;
        endcase
    end

    // Output decode and datapath strobes
    always_comb begin
        cs_n         = 1'b1;
        spi_not_busy = 1'b0;
        start        = 1'b0;
        rise         = 1'b0;
        fall         = 1'b0;
        done         = 1'b0;
        case (state)
            StIdle: begin
                spi_not_busy = 1'b1;
                start        = spi_ena;
            end
            StSetup: begin
                cs_n = 1'b0;
                rise = tick;
            end
            StShift: begin
                cs_n = 1'b0;
                rise = tick & ~sclk;
                fall = tick & sclk;
            end
            StHold: begin
                cs_n = 1'b0;
                done = tick;
            end
            default: begin
                cs_n         = 1'b1;
                spi_not_busy = 1'b0;
            end
        endcase
    end

    // Half-period divider, runs only while a frame is on the wire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= 8'd0;
        end else if (state == StSetup || state == StShift || state == StHold) begin
            div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
        end else begin
            div_cnt <= 8'd0;
        end
    end

    // Serial clock; miso is captured on the same edge that drives sclk high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk <= 1'b0;
        end else if (rise) begin
            sclk <= 1'b1;
        end else if (fall) begin
            sclk <= 1'b0;
        end
    end

    // Shift register and received-bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= 6'd0;
        end else if (start) begin
            shift_reg <= '0;
            bit_cnt   <= 6'd0;
        end else if (rise) begin
            shift_reg <= {shift_reg[NBITS-2:0], miso};
            bit_cnt   <= bit_cnt + 6'd1;
        end
    end

    // Parallel output word and its one-cycle valid strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_rx_data <= '0;
            rx_valid    <= 1'b0;
        end else begin
            rx_valid <= done;
            if (done) begin
                spi_rx_data <= shift_reg;
            end
        end
    end

`ifdef SPI_CS_GAP_EN
    // Counts cycles spent in GAP with cs_n held high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt <= 16'd0;
        end else if (state == StGap) begin
            gap_cnt <= gap_cnt + 16'd1;
        end else begin
            gap_cnt <= 16'd0;
        end
    end
`endif

endmodule

// File: tb/tb_max31855_spi_rx.sv
// Directed bench for max31855_spi_rx: default instance (CLK_DIV=2, NBITS=32)
// plus a CLK_DIV=5, NBITS=16 instance for edge timing.
module tb_max31855_spi_rx;

`ifdef SPI_CS_GAP_EN
    localparam int NbAtDone = 0;
    localparam int CsHigh   = 17;
`else
    localparam int NbAtDone = 1;
    localparam int CsHigh   = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ena_a, ena_b;
    logic        miso_a, miso_b;
    logic        cs_n_a, cs_n_b, sclk_a, sclk_b, nb_a, nb_b, rxv_a, rxv_b;
    logic [31:0] data_a;
    logic [15:0] data_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    max31855_spi_rx u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .spi_ena      (ena_a),
        .miso         (miso_a),
        .cs_n         (cs_n_a),
        .sclk         (sclk_a),
        .spi_not_busy (nb_a),
        .spi_rx_data  (data_a),
        .rx_valid     (rxv_a)
    );

    max31855_spi_rx #(
        .CLK_DIV (5),
        .NBITS   (16)
    ) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .spi_ena      (ena_b),
        .miso         (miso_b),
        .cs_n         (cs_n_b),
        .sclk         (sclk_b),
        .spi_not_busy (nb_b),
        .spi_rx_data  (data_b),
        .rx_valid     (rxv_b)
    );

    // Device models: load word on cs_n fall, shift on sclk fall; between a
    // rise and the next fall miso carries the inverted bit, so a sample taken
    // anywhere but the rising edge corrupts the word.
    logic [31:0] word_a, tx_a;
    logic [15:0] word_b, tx_b;
    logic        junk_a, junk_b, pcs_a, pcs_b, psclk_a, psclk_b;
    logic        tog_en, tog;

    always @(negedge clk) begin
        if (pcs_a && !cs_n_a) begin
            tx_a   <= word_a;
            junk_a <= 1'b0;
        end else if (!psclk_a && sclk_a) begin
            junk_a <= 1'b1;
        end else if (psclk_a && !sclk_a) begin
            tx_a   <= tx_a << 1;
            junk_a <= 1'b0;
        end
        pcs_a   <= cs_n_a;
        psclk_a <= sclk_a;
    end

    always @(negedge clk) begin
        if (pcs_b && !cs_n_b) begin
            tx_b   <= word_b;
            junk_b <= 1'b0;
        end else if (!psclk_b && sclk_b) begin
            junk_b <= 1'b1;
        end else if (psclk_b && !sclk_b) begin
            tx_b   <= tx_b << 1;
            junk_b <= 1'b0;
        end
        pcs_b   <= cs_n_b;
        psclk_b <= sclk_b;
    end

    assign miso_a = tog_en ? tog : (tx_a[31] ^ junk_a);
    assign miso_b = tx_b[15] ^ junk_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Raise the request and advance to the negedge after edge k
    task automatic start_frame(input bit sel);
        if (sel) ena_b = 1'b1;
        else ena_a = 1'b1;
        @(negedge clk);
    endtask

    // Called just after edge k; returns offsets (in edges from k) of events
    task automatic run_frame(input bit sel, output int lat, output int rises, output int busy,
                             output int first_rise, output int last_fall);
        logic ps, s, c;
        lat        = -1;
        rises      = 0;
        first_rise = -1;
        last_fall  = -1;
        busy       = ((sel ? nb_b : nb_a) == 1'b0) ? 1 : 0;
        ps         = sel ? sclk_b : sclk_a;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            s = sel ? sclk_b : sclk_a;
            c = sel ? cs_n_b : cs_n_a;
            if (!ps && s && !c) begin
                rises++;
                if (first_rise < 0) first_rise = i;
            end
            if (ps && !s && !c) last_fall = i;
            ps = s;
            if (sel ? rxv_b : rxv_a) begin
                lat = i;
                break;
            end
            if (!(sel ? nb_b : nb_a)) busy++;
        end
    endtask

    task automatic wait_idle_a(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (nb_a) break;
            @(negedge clk);
        end
        check(tag, 32'(nb_a), 1);
    endtask

    int lat, rises, busy, fr, lf, high, nb_hi, pulses;
    int bad_cs, bad_sclk, bad_data;
    logic [31:0] ref_data;

    initial begin
        rst = 1'b1; ena_a = 1'b0; ena_b = 1'b0; tog_en = 1'b0; tog = 1'b0;
        word_a = '0; word_b = '0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(cs_n_a), 1);
        check("rst_sclk", 32'(sclk_a), 0);
        check("rst_not_busy", 32'(nb_a), 1);
        check("rst_data", data_a, 0);
        check("rst_rx_valid", 32'(rxv_a), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single frame with a one-cycle request pulse
        word_a = 32'hA5C3_0F12;
        start_frame(0);
        ena_a = 1'b0;
        check("sf_cs_n_k", 32'(cs_n_a), 0);
        check("sf_not_busy_k", 32'(nb_a), 0);
        run_frame(0, lat, rises, busy, fr, lf);
        check("sf_latency", lat, 130);
        check("sf_data", data_a, 32'hA5C3_0F12);
        check("sf_rises", rises, 32);
        check("sf_busy_cycles", busy, 130);
        check("sf_cs_n_done", 32'(cs_n_a), 1);
        check("sf_not_busy_done", 32'(nb_a), NbAtDone);
        @(negedge clk);
        check("sf_rx_valid_width", 32'(rxv_a), 0);
        check("sf_data_stable", data_a, 32'hA5C3_0F12);
        wait_idle_a("sf_idle");

        // Held request: two back-to-back frames
        word_a = 32'h0000_0001;
        start_frame(0);
        run_frame(0, lat, rises, busy, fr, lf);
        check("hr1_latency", lat, 130);
        check("hr1_data", data_a, 32'h0000_0001);
        word_a = 32'hFFFF_FFFE;
        check("hr_not_busy_done", 32'(nb_a), NbAtDone);
        high  = 0;
        nb_hi = 0;
        for (int i = 0; i < 100; i++) begin
            if (!cs_n_a) break;
            high++;
            if (nb_a) nb_hi++;
            @(negedge clk);
        end
        ena_a = 1'b0;
        check("hr_cs_n_high", high, CsHigh);
        check("hr_not_busy_between", nb_hi, 1);
        run_frame(0, lat, rises, busy, fr, lf);
        check("hr2_latency", lat, 130);
        check("hr2_data", data_a, 32'hFFFF_FFFE);
        check("hr2_rises", rises, 32);
        wait_idle_a("hr_idle");

        // Edge timing on the CLK_DIV=5, NBITS=16 instance
        word_b = 16'h8001;
        start_frame(1);
        ena_b = 1'b0;
        run_frame(1, lat, rises, busy, fr, lf);
        check("et_first_rise", fr, 5);
        check("et_last_fall", lf, 160);
        check("et_latency", lat, 165);
        check("et_data", 32'(data_b), 32'h0000_8001);
        check("et_rises", rises, 16);

        // Reset at the 10th sclk rise
        word_a = 32'h3C3C_5A5A;
        start_frame(0);
        ena_a = 1'b0;
        rises = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sclk_a && !psclk_a) rises++;
            if (rises == 10) break;
        end
        check("rm_rise10", rises, 10);
        rst = 1'b1;
        #1;
        check("rm_cs_n", 32'(cs_n_a), 1);
        check("rm_sclk", 32'(sclk_a), 0);
        check("rm_not_busy", 32'(nb_a), 1);
        check("rm_data", data_a, 0);
        check("rm_rx_valid", 32'(rxv_a), 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rxv_a) pulses++;
        end
        check("rm_no_pulse", pulses, 0);
        word_a = 32'h1234_5678;
        start_frame(0);
        ena_a = 1'b0;
        run_frame(0, lat, rises, busy, fr, lf);
        check("rm_new_latency", lat, 130);
        check("rm_new_data", data_a, 32'h1234_5678);
        wait_idle_a("rm_idle");

        // Idle stability with miso toggling
        ref_data = data_a;
        tog_en   = 1'b1;
        bad_cs   = 0;
        bad_sclk = 0;
        bad_data = 0;
        pulses   = 0;
        for (int i = 0; i < 1000; i++) begin
            tog = ~tog;
            @(negedge clk);
            if (cs_n_a !== 1'b1) bad_cs++;
            if (sclk_a !== 1'b0) bad_sclk++;
            if (data_a !== ref_data) bad_data++;
            if (rxv_a) pulses++;
        end
        tog_en = 1'b0;
        check("idle_cs_n", bad_cs, 0);
        check("idle_sclk", bad_sclk, 0);
        check("idle_data", bad_data, 0);
        check("idle_rx_valid", pulses, 0);
        check("idle_data_value", data_a, 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
